instruction_memory_pipelined: RTL

- Parametrised successor to the fixed-size, hard-coded instruction ROM.
- Word-organised instruction store with configurable depth and fetch latency, driven by a small FSM that holds BUSYWAIT for a programmable number of cycles.
- Program image is written at run time through a word-wide load port instead of being hard-coded.
- Sits between the IF stage PC and the decoder. Fetch faults (misaligned or out-of-range addresses) are flagged and return a NOP.

---
 rtl/instruction_memory_pipelined.sv | 131 +++++++++++++
 1 files changed

// File: rtl/instruction_memory_pipelined.sv
// Run-time loadable instruction store with programmable fetch latency and fault flagging.
// Optional trace outputs (TRACE_PC/TRACE_INS) are enabled by defining IMEM_TRACE_EN.
module instruction_memory_pipelined #(
  parameter int unsigned DEPTH_WORDS  = 256,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] NOP_WORD     = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic [31:0] READ_ADDRESS,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        FETCH_FAULT,
  input  logic        LOAD_EN,
  input  logic [31:0] LOAD_ADDR,
  input  logic [31:0] LOAD_DATA,
  output logic        LOAD_ACK
`ifdef IMEM_TRACE_EN
  ,
  output logic [39:0] TRACE_PC,
  output logic [39:0] TRACE_INS
`endif
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [31:0]       addr_q;

  // Contents survive reset; only the power-up image is all NOPs.
  logic [31:0]       mem [DEPTH_WORDS] = '{default: NOP_WORD};

  logic [IdxW-1:0]   rd_idx;
  logic              rd_misaligned;
  logic              rd_out_of_range;
  logic              fetch_fault;
  logic [31:0]       fetch_word;

  logic [IdxW-1:0]   ld_idx;
  logic              ld_in_range;
  logic              mem_we;

  logic              unused_load_bits;

  assign rd_idx          = addr_q[IdxW+1:2];
  assign rd_misaligned   = |addr_q[1:0];
  // Upper address bits never alias onto the array.
  assign rd_out_of_range = |addr_q[31:IdxW+2];

  always_comb begin
    fetch_fault = rd_misaligned || rd_out_of_range;
    fetch_word  = NOP_WORD;
    if (!fetch_fault) begin
      fetch_word = mem[rd_idx];
    end
  end

  assign ld_idx           = LOAD_ADDR[IdxW+1:2];
  assign ld_in_range      = ~|LOAD_ADDR[31:IdxW+2];
  assign unused_load_bits = ^LOAD_ADDR[1:0];

  assign mem_we = !RESET && (state_q == StIdle) && LOAD_EN && ld_in_range;

  always_comb begin
    BUSYWAIT = 1'b0;
    if (!RESET) begin
      BUSYWAIT = ((state_q == StIdle) && (READ || LOAD_EN)) || (state_q == StBusy);
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[ld_idx] <= LOAD_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      READ_DATA   <= NOP_WORD;
      FETCH_FAULT <= 1'b0;
      LOAD_ACK    <= 1'b0;
`ifdef IMEM_TRACE_EN
      TRACE_PC    <= '0;
      TRACE_INS   <= '0;
`endif
    end else begin
      LOAD_ACK <= 1'b0;
      case (state_q)
        StIdle: begin
          // A load wins the cycle; a concurrent READ is serviced once LOAD_EN drops.
          if (LOAD_EN) begin
            LOAD_ACK <= 1'b1;
          end else if (READ) begin
            addr_q  <= READ_ADDRESS;
            cnt_q   <= CntW'(READ_LATENCY - 1);
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q     <= StDone;
            READ_DATA   <= fetch_word;
            FETCH_FAULT <= fetch_fault;
`ifdef IMEM_TRACE_EN
            TRACE_PC    <= {addr_q, 8'h1E};
            TRACE_INS   <= 40'({14'd0, fetch_word[31:25], fetch_word[14:12],
                                fetch_word[6:0], 8'h1F});
`endif
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
